uart_pkt_rx_ctrl: RTL and testbench
===================================

// Module: uart_pkt_rx_ctrl
// PURPOSE
//   Packet-level controller behind the UART receiver. Consumes received bytes (rx_dout/rx_done_tick)
//   and frames them as: SOF, LEN, LEN payload bytes, CSUM. Buffers the payload and checks length and checksum.
//   Releases a good packet as a valid/ready byte stream with a last flag; drops bad packets with an error pulse.
//   Sits between uart_rx and the command/register logic. Shares s_tick with uart_rx for the inter-byte timeout.
// PARAMETERS
//   DBIT          8      byte width; must match uart_rx DBIT
//   MAX_LEN       16     maximum payload bytes; buffer depth
//   SOF           8'hA5  start-of-frame byte value (DBIT wide)
//   TIMEOUT_TICKS 640    s_tick count with no byte before an open packet is aborted (4 chars at 16x)
// PORTS
//   clk           in   1      system clock
//   reset_n       in   1      asynchronous active-low reset
//   s_tick        in   1      16x baud oversampling tick (same one that drives uart_rx)
//   rx_dout       in   DBIT   received byte; sampled only when rx_done_tick=1
//   rx_done_tick  in   1      one-cycle strobe: rx_dout holds a new byte
//   m_data        out  DBIT   payload byte
//   m_valid       out  1      m_data is valid
//   m_last        out  1      m_data is the final payload byte of the packet
//   m_ready       in   1      consumer accepts the byte when m_valid & m_ready
//   err_len       out  1      pulse: LEN==0 or LEN>MAX_LEN
//   err_csum      out  1      pulse: checksum mismatch
//   err_timeout   out  1      pulse: inter-byte timeout in an open packet
//   err_ovr       out  1      pulse: byte arrived while draining; byte dropped
// BEHAVIOUR
//   Reset: state=HUNT; all counters and pointers 0; m_valid, m_last, all err_* = 0. Reset mid-packet discards the packet.
//   One clock. Every register uses asynchronous active-low reset on reset_n.
//   HUNT:  on rx_done_tick, if rx_dout==SOF go to LEN; otherwise the byte is discarded silently.
//   LEN:   on a byte, if 0 or >MAX_LEN, pulse err_len and go to HUNT.
//          Otherwise store len, set sum=byte, wr_ptr=0, and go to PAYLOAD.
//   PAYLOAD: on each byte, write buf[wr_ptr], set sum+=byte (mod 2^DBIT), and wr_ptr++.
//          After the len-th byte, go to CSUM.
//   CSUM:  on a byte, if byte==sum go to DRAIN with rd_ptr=0. Otherwise pulse err_csum and go to HUNT.
//   DRAIN: m_valid=1, m_data=buf[rd_ptr], m_last=(rd_ptr==len-1).
//          On m_valid&m_ready, rd_ptr++. The handshake with m_last=1 returns to HUNT on the next cycle.
//          m_data and m_last are stable while m_valid & ~m_ready. m_valid is never dropped without a handshake.
//          Any rx_done_tick in DRAIN pulses err_ovr and drops the byte, including a SOF byte.
//   Latency: csum byte strobe in cycle N -> m_valid=1 in cycle N+1. One byte per cycle when m_ready=1.
//   Timeout: a counter runs only in LEN/PAYLOAD/CSUM.
//          It clears on entry to LEN and on every rx_done_tick, and increments on s_tick.
//          When it reaches TIMEOUT_TICKS-1 and s_tick=1, pulse err_timeout and go to HUNT.
//          If rx_done_tick and the terminal s_tick occur in the same cycle, the byte wins: no timeout, counter clears.
//   Every err_* output is exactly one clk wide and registered. At most one err_* is asserted per cycle.
//   Widths: len/wr_ptr/rd_ptr are $clog2(MAX_LEN+1) bits. Timeout counter is $clog2(TIMEOUT_TICKS+1) bits.
//          The checksum is DBIT bits and wraps modulo 2^DBIT.
//   The buffer is not cleared between packets. Only wr_ptr/rd_ptr are reset.
// STRUCTURE
//   uart_defs.vh: state encodings (HUNT, LEN, PAYLOAD, CSUM, DRAIN) and the default SOF value.
//            uart_rx and uart_tx include the same file.
//   Sub-module uart_pkt_buf: MAX_LEN x DBIT register file with one synchronous write port and one
//            asynchronous read port. No reset on storage.
//   Top level: 2-process FSM (state register + combinational next-state), counters, checksum, error registers.
// TESTING
//   1. A5 03 11 22 33 69 with m_ready=1 -> m_data 11,22,33 on 3 consecutive cycles.
//      m_last only with 33; no err_*.
//   2. A5 03 11 22 33 6A -> single err_csum pulse; m_valid stays 0; a following good packet is delivered.
//   3. A5 00 -> err_len. A5 11 (17>MAX_LEN) -> err_len. Both return to HUNT; no m_valid.
//   4. A5 02 AA then 640 s_ticks idle -> err_timeout on the 640th tick.
//      A byte arriving on that same tick suppresses the timeout.
//   5. 00 FF 3C, then A5 01 7E 7F -> leading bytes ignored; m_data=7E with m_last.
//      Hold m_ready=0 and send 55 during DRAIN -> err_ovr, m_data still 7E.
//   6. reset_n low mid-PAYLOAD (async, between clk edges) -> outputs 0 immediately.
//      After release, A5 01 7E 7F is delivered correctly.

Source files
------------

// File: rtl/uart_pkt_rx_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_pkt_rx_ctrl_pkg
// Description : Shared types and constants for the UART packet receiver:
//               framing FSM state encoding, default SOF value, width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkt_rx_ctrl_pkg;

  // Framing states: SOF hunt, length byte, payload bytes, checksum, drain.
  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_DRAIN   = 3'd4
  } state_e;

  localparam logic [7:0] DEFAULT_SOF = 8'hA5;

  // Address width for an n-entry storage array, never narrower than 1 bit.
  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_pkt_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_pkt_buf
// Description : DEPTH x DBIT payload register file. One synchronous write
//               port, one asynchronous read port, storage is not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_pkt_buf #(
  parameter int DBIT  = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [DBIT-1:0] wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [DBIT-1:0] rdata_o
);

  logic [DBIT-1:0] mem_q [DEPTH];

  // Payload write; contents survive between packets, only pointers restart.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/uart_pkt_rx_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_pkt_rx_ctrl
// Description : Frames bytes from uart_rx as SOF, LEN, payload, CSUM; buffers
//               the payload, checks length/checksum and releases good packets
//               as a valid/ready stream with a last flag. Bad or stalled
//               packets are dropped with a one-cycle registered error pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_pkt_rx_ctrl
  import uart_pkt_rx_ctrl_pkg::*;
#(
  parameter int              DBIT          = 8,
  parameter int              MAX_LEN       = 16,
  parameter logic [DBIT-1:0] SOF           = DBIT'(DEFAULT_SOF),
  parameter int              TIMEOUT_TICKS = 640
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic [DBIT-1:0] rx_dout,
  input  logic            rx_done_tick,
  output logic [DBIT-1:0] m_data,
  output logic            m_valid,
  output logic            m_last,
  input  logic            m_ready,
  output logic            err_len,
  output logic            err_csum,
  output logic            err_timeout,
  output logic            err_ovr
);

  localparam int              LW        = $clog2(MAX_LEN + 1);
  localparam int              TW        = $clog2(TIMEOUT_TICKS + 1);
  localparam int              AW        = addr_width(MAX_LEN);
  localparam logic [DBIT-1:0] MAX_LEN_B = DBIT'(MAX_LEN);
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_TICKS - 1);

  state_e          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DBIT-1:0] sum_q, sum_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            err_len_q, err_len_d;
  logic            err_csum_q, err_csum_d;
  logic            err_tmo_q, err_tmo_d;
  logic            err_ovr_q, err_ovr_d;
  logic            buf_we;
  logic            pkt_open;
  logic            tmo_hit;
  logic            last_beat;
  logic [DBIT-1:0] buf_rdata;

  uart_pkt_buf #(
    .DBIT  (DBIT),
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (rx_dout),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (buf_rdata)
  );

  // A packet is "open" once SOF has been seen and until its checksum arrives.
  assign pkt_open  = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
  // A byte landing on the terminal tick beats the timeout.
  assign tmo_hit   = pkt_open && s_tick && !rx_done_tick && (tmo_q == TMO_LAST);
  assign last_beat = (rd_ptr_q == len_q - LW'(1));

  // State, pointers, checksum and error pulses, all async active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_HUNT;
      len_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sum_q      <= '0;
      tmo_q      <= '0;
      err_len_q  <= 1'b0;
      err_csum_q <= 1'b0;
      err_tmo_q  <= 1'b0;
      err_ovr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sum_q      <= sum_d;
      tmo_q      <= tmo_d;
      err_len_q  <= err_len_d;
      err_csum_q <= err_csum_d;
      err_tmo_q  <= err_tmo_d;
      err_ovr_q  <= err_ovr_d;
    end
  end

  // Next-state, datapath updates and error detection for the framing FSM.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    sum_d      = sum_q;
    tmo_d      = '0;
    err_len_d  = 1'b0;
    err_csum_d = 1'b0;
    err_tmo_d  = 1'b0;
    err_ovr_d  = 1'b0;
    buf_we     = 1'b0;

    // Idle counter only runs inside an open packet; any byte restarts it.
    if (pkt_open && !rx_done_tick) begin
      tmo_d = s_tick ? (tmo_q + TW'(1)) : tmo_q;
    end

    case (state_q)
      ST_HUNT: begin
        if (rx_done_tick && (rx_dout == SOF)) begin
          state_d = ST_LEN;
        end
      end

      ST_LEN: begin
        if (rx_done_tick) begin
          if ((rx_dout == '0) || (rx_dout > MAX_LEN_B)) begin
            err_len_d = 1'b1;
            state_d   = ST_HUNT;
          end else begin
            len_d    = rx_dout[LW-1:0];
            sum_d    = rx_dout;
            wr_ptr_d = '0;
            state_d  = ST_PAYLOAD;
          end
        end else if (tmo_hit) begin
          err_tmo_d = 1'b1;
          state_d   = ST_HUNT;
        end
      end

      ST_PAYLOAD: begin
        if (rx_done_tick) begin
          buf_we   = 1'b1;
          sum_d    = sum_q + rx_dout;
          wr_ptr_d = wr_ptr_q + LW'(1);
          if (wr_ptr_q == len_q - LW'(1)) begin
            state_d = ST_CSUM;
          end
        end else if (tmo_hit) begin
          err_tmo_d = 1'b1;
          state_d   = ST_HUNT;
        end
      end

      ST_CSUM: begin
        if (rx_done_tick) begin
          if (rx_dout == sum_q) begin
            rd_ptr_d = '0;
            state_d  = ST_DRAIN;
          end else begin
            err_csum_d = 1'b1;
            state_d    = ST_HUNT;
          end
        end else if (tmo_hit) begin
          err_tmo_d = 1'b1;
          state_d   = ST_HUNT;
        end
      end

      ST_DRAIN: begin
        // No room to start another packet while draining: drop and flag.
        err_ovr_d = rx_done_tick;
        if (m_ready) begin
          rd_ptr_d = rd_ptr_q + LW'(1);
          if (last_beat) begin
            state_d = ST_HUNT;
          end
        end
      end

      default: begin
        state_d = ST_HUNT;
      end
    endcase
  end

  assign m_valid     = (state_q == ST_DRAIN);
  assign m_last      = (state_q == ST_DRAIN) && last_beat;
  assign m_data      = buf_rdata;
  assign err_len     = err_len_q;
  assign err_csum    = err_csum_q;
  assign err_timeout = err_tmo_q;
  assign err_ovr     = err_ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_pkt_rx_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_pkt_rx_ctrl
// Description : Self-checking bench for uart_pkt_rx_ctrl. Expected payload
//               beats are queued as packets are sent and popped on handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_pkt_rx_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_tick = 1'b0;
  logic [7:0] rx_dout = 8'h00;
  logic       rx_done_tick = 1'b0;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       err_len;
  logic       err_csum;
  logic       err_timeout;
  logic       err_ovr;

  int n_checks = 0;
  int n_pass   = 0;
  int cnt_len = 0, cnt_csum = 0, cnt_tmo = 0, cnt_ovr = 0, cnt_valid = 0;

  logic [8:0] exp_q [$];
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  uart_pkt_rx_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_tick       (s_tick),
    .rx_dout      (rx_dout),
    .rx_done_tick (rx_done_tick),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_last       (m_last),
    .m_ready      (m_ready),
    .err_len      (err_len),
    .err_csum     (err_csum),
    .err_timeout  (err_timeout),
    .err_ovr      (err_ovr)
  );

  always #5 clk = ~clk;

  // Output monitor: scoreboard pops, hold stability, error pulse counting.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last)
          $display("FAIL hold_stable: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                   m_valid, m_data, m_last, prev_data, prev_last);
        else n_pass++;
      end
      if (m_valid === 1'b1) cnt_valid++;
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_beat: got d=%h l=%b, want no output", m_data, m_last);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          if ({m_last, m_data} !== e)
            $display("FAIL beat: got d=%h l=%b, want d=%h l=%b", m_data, m_last, e[7:0], e[8]);
          else n_pass++;
        end
      end
      prev_hold = (m_valid === 1'b1) && (m_ready !== 1'b1);
      prev_data = m_data;
      prev_last = m_last;
      if (err_len === 1'b1)     cnt_len++;
      if (err_csum === 1'b1)    cnt_csum++;
      if (err_timeout === 1'b1) cnt_tmo++;
      if (err_ovr === 1'b1)     cnt_ovr++;
      if ((err_len | err_csum | err_timeout | err_ovr) === 1'b1) begin
        n_checks++;
        if ($countones({err_len, err_csum, err_timeout, err_ovr}) != 1)
          $display("FAIL err_onehot: got %b, want one bit",
                   {err_len, err_csum, err_timeout, err_ovr});
        else n_pass++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_dout      = b;
    rx_done_tick = 1'b1;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
  endtask

  task automatic send_good(input int len, input logic [7:0] first,
                           input logic [7:0] step, input bit push);
    logic [7:0] sum;
    logic [7:0] d;
    sum = 8'(len);
    send_byte(8'hA5);
    send_byte(8'(len));
    for (int i = 0; i < len; i++) begin
      d   = first + 8'(i) * step;
      sum = sum + d;
      if (push) exp_q.push_back({(i == len - 1), d});
      send_byte(d);
    end
    send_byte(sum);
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || m_valid === 1'b1) && n < budget) begin
      idle(1);
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0 || m_valid === 1'b1) begin
      $display("FAIL %s_drain: got %0d beats left, want 0", name, exp_q.size());
      exp_q.delete();
    end else n_pass++;
  endtask

  task automatic tick_s(input int n);
    repeat (n) begin
      s_tick = 1'b1;
      @(posedge clk); #1;
      s_tick = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    idle(3);
    n_checks++;
    if ({m_valid, m_last, err_len, err_csum, err_timeout, err_ovr} !== 6'b0)
      $display("FAIL reset_outputs: got %b, want 000000",
               {m_valid, m_last, err_len, err_csum, err_timeout, err_ovr});
    else n_pass++;
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    int e0 = cnt_len + cnt_csum + cnt_tmo + cnt_ovr;
    m_ready = 1'b1;
    send_good(3, 8'h11, 8'h11, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (m_valid !== 1'b1 || m_last !== (i == 2))
        $display("FAIL basic_beat%0d: got v=%b l=%b, want v=1 l=%b", i, m_valid, m_last, (i == 2));
      else n_pass++;
      idle(1);
    end
    n_checks++;
    if (m_valid !== 1'b0) $display("FAIL basic_end: got v=%b, want 0", m_valid);
    else n_pass++;
    wait_empty("basic", 10);
    n_checks++;
    if (cnt_len + cnt_csum + cnt_tmo + cnt_ovr != e0)
      $display("FAIL basic_noerr: got %0d errors, want 0", cnt_len + cnt_csum + cnt_tmo + cnt_ovr - e0);
    else n_pass++;
  endtask

  task automatic test_bad_csum();
    int c0 = cnt_csum;
    int v0 = cnt_valid;
    m_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h6A);
    idle(3);
    n_checks++;
    if (cnt_csum - c0 != 1) $display("FAIL csum_err: got %0d pulses, want 1", cnt_csum - c0);
    else n_pass++;
    n_checks++;
    if (cnt_valid != v0) $display("FAIL csum_novalid: got %0d valid cycles, want 0", cnt_valid - v0);
    else n_pass++;
    send_good(2, 8'h40, 8'h01, 1'b1);
    wait_empty("after_csum", 10);
  endtask

  task automatic test_bad_len();
    int c0 = cnt_len;
    int v0 = cnt_valid;
    m_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h00);
    idle(2);
    send_byte(8'hA5); send_byte(8'h11);
    idle(2);
    n_checks++;
    if (cnt_len - c0 != 2) $display("FAIL len_err: got %0d pulses, want 2", cnt_len - c0);
    else n_pass++;
    n_checks++;
    if (cnt_valid != v0) $display("FAIL len_novalid: got %0d valid cycles, want 0", cnt_valid - v0);
    else n_pass++;
    send_good(1, 8'hC3, 8'h00, 1'b1);
    wait_empty("after_len", 10);
  endtask

  task automatic test_timeout();
    int t0 = cnt_tmo;
    m_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA);
    tick_s(639);
    n_checks++;
    if (cnt_tmo != t0) $display("FAIL tmo_early: got %0d pulses, want 0", cnt_tmo - t0);
    else n_pass++;
    tick_s(1);
    n_checks++;
    if (cnt_tmo - t0 != 1) $display("FAIL tmo_fire: got %0d pulses, want 1", cnt_tmo - t0);
    else n_pass++;
    send_good(1, 8'h5A, 8'h00, 1'b1);
    wait_empty("after_tmo", 10);
    // Byte coincident with the terminal tick must win.
    t0 = cnt_tmo;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA);
    tick_s(639);
    exp_q.push_back({1'b0, 8'hAA});
    exp_q.push_back({1'b1, 8'hBB});
    s_tick       = 1'b1;
    rx_dout      = 8'hBB;
    rx_done_tick = 1'b1;
    @(posedge clk); #1;
    s_tick       = 1'b0;
    rx_done_tick = 1'b0;
    idle(2);
    n_checks++;
    if (cnt_tmo != t0) $display("FAIL tmo_suppress: got %0d pulses, want 0", cnt_tmo - t0);
    else n_pass++;
    send_byte(8'h67);
    wait_empty("tmo_suppress", 10);
  endtask

  task automatic test_hunt_ovr();
    int o0 = cnt_ovr;
    m_ready = 1'b0;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h3C);
    send_good(1, 8'h7E, 8'h00, 1'b1);
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h7E || m_last !== 1'b1)
      $display("FAIL hunt_beat: got v=%b d=%h l=%b, want v=1 d=7e l=1", m_valid, m_data, m_last);
    else n_pass++;
    send_byte(8'h55);
    idle(1);
    send_byte(8'hA5);
    idle(1);
    n_checks++;
    if (cnt_ovr - o0 != 2) $display("FAIL ovr_err: got %0d pulses, want 2", cnt_ovr - o0);
    else n_pass++;
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h7E)
      $display("FAIL ovr_hold: got v=%b d=%h, want v=1 d=7e", m_valid, m_data);
    else n_pass++;
    m_ready = 1'b1;
    wait_empty("ovr", 10);
  endtask

  task automatic test_max_len();
    int n = 0;
    m_ready = 1'b1;
    send_good(16, 8'h01, 8'h07, 1'b1);
    while ((exp_q.size() != 0 || m_valid === 1'b1) && n < 200) begin
      m_ready = 1'($urandom_range(0, 1));
      idle(1);
      n++;
    end
    m_ready = 1'b1;
    wait_empty("max_len", 40);
  endtask

  task automatic test_back_to_back();
    int o0 = cnt_ovr;
    m_ready = 1'b1;
    send_good(2, 8'h10, 8'h03, 1'b1);
    idle(2);
    send_good(3, 8'hF0, 8'h09, 1'b1);
    idle(3);
    send_good(1, 8'h00, 8'h00, 1'b1);
    wait_empty("b2b", 10);
    n_checks++;
    if (cnt_ovr != o0) $display("FAIL b2b_noovr: got %0d pulses, want 0", cnt_ovr - o0);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    m_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    #3 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({m_valid, m_last, err_len, err_csum, err_timeout, err_ovr} !== 6'b0)
      $display("FAIL rst_payload: got %b, want 000000",
               {m_valid, m_last, err_len, err_csum, err_timeout, err_ovr});
    else n_pass++;
    idle(2);
    reset_n = 1'b1;
    idle(1);
    send_good(1, 8'h7E, 8'h00, 1'b1);
    wait_empty("after_rst", 10);
    // Reset while a beat is stalled must kill m_valid without a clock edge.
    m_ready = 1'b0;
    send_good(1, 8'h3D, 8'h00, 1'b0);
    n_checks++;
    if (m_valid !== 1'b1) $display("FAIL rst_predrain: got v=%b, want 1", m_valid);
    else n_pass++;
    #3 reset_n = 1'b0;
    #1;
    n_checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0)
      $display("FAIL rst_drain: got v=%b l=%b, want v=0 l=0", m_valid, m_last);
    else n_pass++;
    idle(2);
    reset_n = 1'b1;
    m_ready = 1'b1;
    idle(1);
    send_good(2, 8'h21, 8'h11, 1'b1);
    wait_empty("after_rst2", 10);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_bad_len();
    test_timeout();
    test_hunt_ovr();
    test_max_len();
    test_back_to_back();
    test_async_reset();
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
